// File: rtl/led_matrix_pkg.sv
// Shared geometry and scan-state encoding for the 8x8 LED matrix blocks.
package led_matrix_pkg;

  localparam int N_ROWS   = 8;
  localparam int N_COLS   = 8;
  localparam int ROW_BITS = 3;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/led_row_scanner.sv
// Row-multiplexing scan controller: blank then drive each row, frame double-buffered at row-0 blank.
// Latency: frame loaded at the handshake edge, first shown when row 0 drives (BLANK_TICKS cycles later).
// Backpressure: frame_ready only during the row-0 blanking window; the source holds frame_valid until accepted.
module led_row_scanner
  import led_matrix_pkg::*;
#(
  parameter int DWELL_TICKS = 1000,
  parameter int BLANK_TICKS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [N_ROWS*N_COLS-1:0]   frame_in,
  input  logic                       frame_valid,
  output logic                       frame_ready,
  output logic [ROW_BITS-1:0]        row_sel,
  output logic                       row_ena,
  output logic [N_COLS-1:0]          col_data,
  output logic                       frame_start
);

  localparam int MAX_TICKS = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_TICKS - 1);

  scan_state_t                 state, state_nxt;
  logic [CNT_W-1:0]            count, count_nxt;
  logic [ROW_BITS-1:0]         row_sel_nxt;
  logic [N_ROWS*N_COLS-1:0]    buffer;
  logic [N_COLS-1:0]           row_data;
  logic                        at_frame_top;

  // row_sel only advances on the drive->blank edge, so the decoder input is
  // never changing while it is enabled.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count + CNT_W'(1);
    row_sel_nxt = row_sel;
    case (state)
      S_BLANK: begin
        if (count == BLANK_LAST) begin
          count_nxt = '0;
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (count == DWELL_LAST) begin
          count_nxt   = '0;
          row_sel_nxt = row_sel + ROW_BITS'(1);
          state_nxt   = S_BLANK;
        end
      end
      default: begin
        count_nxt = '0;
        state_nxt = S_BLANK;
      end
    endcase
  end

  always_comb begin
    at_frame_top = (state == S_BLANK) && (row_sel == '0);
    frame_ready  = ena && at_frame_top;
    frame_start  = frame_ready && (count == '0);
    row_ena      = ena && (state == S_DRIVE);
    row_data     = buffer[row_sel*N_COLS +: N_COLS];
    col_data     = row_ena ? row_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_BLANK;
      count   <= '0;
      row_sel <= '0;
      buffer  <= '0;
    end else begin
      if (ena) begin
        state   <= state_nxt;
        count   <= count_nxt;
        row_sel <= row_sel_nxt;
      end
      // frame_ready already folds in ena, so a frozen scan never swaps frames.
      if (frame_valid && frame_ready) begin
        buffer <= frame_in;
      end
    end
  end

endmodule

// File: tb/tb_led_row_scanner.sv
// Directed bench for led_row_scanner with DWELL_TICKS=4, BLANK_TICKS=2 (48-cycle frame).
module tb_led_row_scanner;
  import led_matrix_pkg::*;

  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int ROWP  = DW + BL;
  localparam int FRAME = 8 * ROWP;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [63:0] frame_in;
  logic        frame_valid;
  logic        frame_ready;
  logic [2:0]  row_sel;
  logic        row_ena;
  logic [7:0]  col_data;
  logic        frame_start;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          tick;
  logic [63:0] exp_buf;

  always #5 clk = ~clk;

  led_row_scanner #(.DWELL_TICKS(DW), .BLANK_TICKS(BL)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .frame_in    (frame_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .row_sel     (row_sel),
    .row_ena     (row_ena),
    .col_data    (col_data),
    .frame_start (frame_start)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference timeline: tick counts enabled cycles since reset.
  task automatic chk_all(input string tag);
    int ph, r;
    logic drv;
    ph  = tick % FRAME;
    r   = ph / ROWP;
    drv = ena && ((ph % ROWP) >= BL);
    chk({tag, ".row_sel"},     64'(row_sel),     64'(r));
    chk({tag, ".row_ena"},     64'(row_ena),     64'(drv));
    chk({tag, ".col_data"},    64'(col_data),    drv ? 64'(exp_buf[8*r +: 8]) : 64'h0);
    chk({tag, ".frame_ready"}, 64'(frame_ready), 64'(ena && ph < BL));
    chk({tag, ".frame_start"}, 64'(frame_start), 64'(ena && ph == 0));
  endtask

  task automatic step(input string tag);
    logic        hs;
    logic [63:0] fi;
    hs = frame_valid && ena && ((tick % FRAME) < BL);
    fi = frame_in;
    @(posedge clk);
    #1;
    if (rst) begin
      tick    = 0;
      exp_buf = '0;
    end else begin
      if (hs) exp_buf = fi;
      if (ena) tick++;
    end
    chk_all(tag);
  endtask

  function automatic int cur_row();
    return (tick % FRAME) / ROWP;
  endfunction

  function automatic bit in_drive();
    return ((tick % FRAME) % ROWP) >= BL;
  endfunction

  initial begin
    logic [63:0] fa, fb;
    logic [2:0]  prev_sel;
    logic        prev_ena;
    int          pulses, changes;

    rst = 1'b1; ena = 1'b0; frame_valid = 1'b0; frame_in = '0;
    tick = 0; exp_buf = '0;
    fa = 64'h0123456789ABCDEF;
    fb = 64'hFEDCBA9876543210;

    step("reset0");
    step("reset1");
    chk("reset_ready_dis", 64'(frame_ready), 64'h0);

    // Free run
    rst = 1'b0; ena = 1'b1; #1;
    chk_all("enable");
    chk("reset_start", 64'(frame_start), 64'h1);
    chk("reset_ready", 64'(frame_ready), 64'h1);
    pulses = 1; changes = 0;
    for (int i = 0; i < FRAME; i++) begin
      prev_sel = row_sel; prev_ena = row_ena;
      step("free");
      if (prev_ena && row_ena && row_sel != prev_sel) changes++;
      if (i < FRAME - 1) pulses += int'(frame_start);
    end
    chk("fs_once", 64'(pulses), 64'h1);
    chk("fs_period", 64'(frame_start), 64'h1);
    chk("sel_stable", 64'(changes), 64'h0);

    // Frame load in row-0 blank
    frame_in = 64'h8040201008040201; frame_valid = 1'b1; #1;
    chk("load_ready", 64'(frame_ready), 64'h1);
    step("load");
    frame_valid = 1'b0;
    for (int i = 0; i < FRAME - 1; i++) begin
      step("diag");
      if (in_drive()) chk("diag_col", 64'(col_data), 64'(8'h01) << cur_row());
    end

    // Valid raised during row 3 must wait for the next window
    for (int i = 0; i < 3 * ROWP; i++) step("adv3");
    frame_in = 64'hFF; frame_valid = 1'b1; #1;
    for (int i = 0; i < FRAME - 3 * ROWP; i++) begin
      chk("oow_ready", 64'(frame_ready), 64'h0);
      step("oow");
      if (in_drive() && cur_row() != 0)
        chk("oow_old_col", 64'(col_data), 64'(8'h01) << cur_row());
    end
    chk("win_ready", 64'(frame_ready), 64'h1);
    step("load_ff");
    frame_valid = 1'b0;
    for (int i = 0; i < FRAME - 1; i++) begin
      step("ff");
      if (in_drive()) chk("ff_col", 64'(col_data), (cur_row() == 0) ? 64'hFF : 64'h0);
    end

    // Pause after the 2nd drive cycle of row 5
    for (int i = 0; i < 5 * ROWP + BL + 2; i++) step("adv5");
    ena = 1'b0; #1;
    for (int i = 0; i < 10; i++) begin
      chk("pause_ena", 64'(row_ena), 64'h0);
      chk("pause_sel", 64'(row_sel), 64'h5);
      chk("pause_col", 64'(col_data), 64'h0);
      step("pause");
    end
    ena = 1'b1; #1;
    chk("resume_ena1", 64'(row_ena), 64'h1);
    chk("resume_sel1", 64'(row_sel), 64'h5);
    step("resume1");
    chk("resume_ena2", 64'(row_ena), 64'h1);
    step("resume2");
    chk("resume_blank", 64'(row_ena), 64'h0);
    chk("resume_row6", 64'(row_sel), 64'h6);

    // Reset during row 6 drive
    step("adv6a");
    step("adv6b");
    chk("pre_rst_drive", 64'(row_ena), 64'h1);
    rst = 1'b1;
    step("rst_mid");
    chk("rst_sel", 64'(row_sel), 64'h0);
    chk("rst_ena", 64'(row_ena), 64'h0);
    chk("rst_col", 64'(col_data), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      step("post_rst");
      chk("post_rst_col", 64'(col_data), 64'h0);
    end

    // Back-to-back loads in one window: last one wins
    frame_in = fa; frame_valid = 1'b1;
    step("b2b_a");
    frame_in = fb; #1;
    chk("b2b_ready", 64'(frame_ready), 64'h1);
    step("b2b_b");
    frame_valid = 1'b0;
    for (int i = 0; i < FRAME - 2; i++) begin
      step("b2b");
      if (in_drive()) chk("b2b_col", 64'(col_data), 64'(fb[8*cur_row() +: 8]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
